wb_burst_reader: RTL and testbench
==================================

// Module: wb_burst_reader
// PURPOSE
//  Wishbone B3 read master that sits directly upstream of wb_bram: it drives
//  wb_bram's slave port and fetches a block of words as incrementing bursts.
//  Words are pushed into an internal FIFO and presented on a valid/ready stream
//  for downstream consumers (e.g. a scan-out or line buffer).
//  Bursts are issued only when the FIFO has room for the whole burst, so the
//  block never has to stall an acknowledge.
// PARAMETERS
//  ADDR    9   word-address width (matches wb_bram default depth)
//  WIDTH   32  data width; byte selects = WIDTH/8
//  BURST   4   max beats per burst (>=1)
//  FLOG2   4   log2 FIFO depth (depth >= BURST required)
// PORTS
//  wb_clk_i   in   1          clock
//  wb_rst_i   in   1          synchronous active-high reset
//  start_i    in   1          start request; accepted only in IDLE
//  base_i     in   ADDR       first word address, sampled on accepted start
//  count_i    in   ADDR+1     words to read, sampled on accepted start
//  busy_o     out  1          transfer in progress
//  done_o     out  1          1-cycle pulse when the transfer ends
//  err_o      out  1          bus error flag (see CONFIGURATION)
//  wb_cyc_o   out  1          bus cycle
//  wb_stb_o   out  1          strobe
//  wb_we_o    out  1          tied 0
//  wb_cti_o   out  3          3'b010 mid-burst beat, 3'b111 last beat
//  wb_bte_o   out  2          tied 2'b00 (linear)
//  wb_adr_o   out  ADDR       current word address
//  wb_sel_o   out  WIDTH/8    all ones
//  wb_ack_i   in   1          slave acknowledge
//  wb_err_i   in   1          slave error
//  wb_dat_i   in   WIDTH      read data
//  data_o     out  WIDTH      FIFO head word
//  valid_o    out  1          FIFO not empty
//  ready_i    in   1          consumer pop; pop = valid_o & ready_i
// BEHAVIOUR
//  - Reset: busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, valid_o = 0; wb_cti_o = 0;
//    wb_adr_o = 0; FIFO emptied. Reset mid-burst drops cyc/stb at that edge; no done_o.
//  - FSM IDLE -> WAIT on start_i (busy_o=1 next cycle); count_i==0 -> DONE instead.
//  - WAIT: n = min(BURST, remaining). Enter BURST when FIFO free slots >= n
//    (free computed from registered level; same-cycle pops not credited).
//  - BURST: cyc/stb high, adr advances by 1 on every ack; cti=010 until the beat
//    where beats_left==1, then 111 (single-beat burst: 111 only).
//    Each ack pushes wb_dat_i into FIFO. Slave wait states: hold all outputs.
//  - After last ack of a burst: cyc/stb drop for >=1 cycle; remaining>0 -> WAIT,
//    else DONE. DONE: done_o=1 for one cycle, busy_o=0, -> IDLE.
//  - done_o reflects bus completion; FIFO may still hold unread words.
//  - Address wraps modulo 2^ADDR, also within a burst (bte stays linear).
//  - start_i while busy_o ignored. start_i in DONE cycle ignored.
//  - FIFO push+pop same cycle: level unchanged. Full on ack is impossible by
//    construction; assertion in sim. Data order strictly ascending address.
// CONFIGURATION
//  WB_BURST_READER_ERR_EN defined: wb_err_i in BURST ends the cycle at that edge
//    (no push), err_o=1 sticky until next accepted start, remaining words
//    abandoned, -> DONE. Words already in FIFO are kept.
//  Undefined: wb_err_i ignored; err_o tied 0; bursts complete on ack only.
// TESTING
//  1 base=0,count=8,BURST=4, bram preloaded i->i: two bursts, cti 2,2,2,7 each,
//    cyc low >=1 cycle between; stream yields 0..7; done_o once; busy 0 after.
//  2 count=6: bursts of 4 then 2 (cti 2,7); stream 0..5.
//  3 base=510,count=4,ADDR=9: adr 510,511,0,1; data in that order.
//  4 ready_i=0, count=32, depth 16: exactly 16 words fetched then cyc held low;
//    release ready_i -> fetch resumes, all 32 delivered in order, no drop.
//  5 count=0: done_o pulse 1 cycle after start, wb_cyc_o never asserted.
//  6 ERR_EN: slave raises err on beat 2 of burst 1 -> cyc drops, err_o=1,
//    done_o pulses, stream yields word 0 only; next start clears err_o.

Source files
------------

// File: rtl/wb_burst_reader.sv
// Wishbone B3 incrementing-burst read master that streams fetched words out through a FIFO.
// Optional bus-error abort is enabled by defining WB_BURST_READER_ERR_EN.
module wb_burst_reader #(
    parameter int unsigned ADDR  = 9,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BURST = 4,
    parameter int unsigned FLOG2 = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               start_i,
    input  logic [ADDR-1:0]    base_i,
    input  logic [ADDR:0]      count_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic               wb_we_o,
    output logic [2:0]         wb_cti_o,
    output logic [1:0]         wb_bte_o,
    output logic [ADDR-1:0]    wb_adr_o,
    output logic [WIDTH/8-1:0] wb_sel_o,
    input  logic               wb_ack_i,
    input  logic               wb_err_i,
    input  logic [WIDTH-1:0]   wb_dat_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               valid_o,
    input  logic               ready_i
);
    localparam int unsigned RW    = ADDR + 1;
    localparam int unsigned BLW   = $clog2(BURST + 1);
    localparam int unsigned DEPTH = 1 << FLOG2;
    localparam int unsigned LW    = FLOG2 + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;
    state_t state, state_d;

    logic [RW-1:0]    remaining;
    logic [BLW-1:0]   beats_left, beats_d, burst_n;
    logic [LW-1:0]    level, level_d;
    logic [FLOG2-1:0] wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             bus_err, ack_hit, last_beat, room, push, pop;
    logic             cyc_d, busy_d, done_d;
    logic [2:0]       cti_d;

    assign wb_we_o  = 1'b0;
    assign wb_bte_o = 2'b00;
    assign wb_sel_o = '1;

`ifdef WB_BURST_READER_ERR_EN
    assign bus_err = (state == S_BURST) && wb_err_i;
`else
    logic unused_err;
    assign unused_err = wb_err_i;
    assign bus_err    = 1'b0;
`endif

    assign ack_hit   = (state == S_BURST) && wb_ack_i && !bus_err;
    assign last_beat = (beats_left == BLW'(1));
    assign burst_n   = (remaining >= RW'(BURST)) ? BLW'(BURST) : BLW'(remaining);
    // Free space uses the registered level only, so a whole burst always fits.
    assign room      = (LW'(DEPTH) - level) >= LW'(burst_n);
    assign push      = ack_hit;
    assign pop       = valid_o && ready_i;
    assign data_o    = mem[rd_ptr];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start_i) state_d = (count_i == '0) ? S_DONE : S_WAIT;
            S_WAIT:  if (room) state_d = S_BURST;
            S_BURST: begin
                if (bus_err)                    state_d = S_DONE;
                else if (ack_hit && last_beat)  state_d = (remaining == RW'(1)) ? S_DONE : S_WAIT;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        beats_d = beats_left;
        if (state == S_WAIT && room) beats_d = burst_n;
        else if (ack_hit)            beats_d = beats_left - BLW'(1);
    end

    always_comb begin
        cyc_d  = (state_d == S_BURST);
        busy_d = (state_d == S_WAIT) || (state_d == S_BURST);
        done_d = (state_d == S_DONE);
        cti_d  = 3'b000;
        if (state_d == S_BURST) cti_d = (beats_d == BLW'(1)) ? 3'b111 : 3'b010;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            wb_cti_o <= 3'b000;
        end else begin
            wb_cyc_o <= cyc_d;
            wb_stb_o <= cyc_d;
            busy_o   <= busy_d;
            done_o   <= done_d;
            wb_cti_o <= cti_d;
        end
    end

    // Transfer bookkeeping: address, words outstanding, beats in current burst, sticky error.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_adr_o   <= '0;
            remaining  <= '0;
            beats_left <= '0;
            err_o      <= 1'b0;
        end else begin
            beats_left <= beats_d;
            if (state == S_IDLE && start_i) begin
                wb_adr_o  <= base_i;
                remaining <= count_i;
                err_o     <= 1'b0;
            end else if (ack_hit) begin
                wb_adr_o  <= wb_adr_o + ADDR'(1);
                remaining <= remaining - RW'(1);
            end
            if (bus_err) err_o <= 1'b1;
        end
    end

    always_comb level_d = level + LW'(push) - LW'(pop);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            valid_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FLOG2'(1);
            if (pop)  rd_ptr <= rd_ptr + FLOG2'(1);
            level   <= level_d;
            valid_o <= (level_d != '0);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= wb_dat_i;
    end

    a_no_overflow: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
        !(push && level == LW'(DEPTH)));

endmodule

// File: tb/tb_wb_burst_reader.sv
// Scoreboarded bench for wb_burst_reader: random wait-state slave, random consumer,
// expected bus beats and stream words produced by a per-transfer burst-splitting model.
module tb_wb_burst_reader;
    localparam int unsigned ADDR  = 9;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned BURST = 4;
    localparam int unsigned FLOG2 = 4;
    localparam int unsigned DEPTH = 1 << FLOG2;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic [ADDR-1:0]    base_i;
    logic [ADDR:0]      count_i;
    logic               busy_o, done_o, err_o;
    logic               wb_cyc_o, wb_stb_o, wb_we_o;
    logic [2:0]         wb_cti_o;
    logic [1:0]         wb_bte_o;
    logic [ADDR-1:0]    wb_adr_o;
    logic [WIDTH/8-1:0] wb_sel_o;
    logic               wb_ack_i, wb_err_i;
    logic [WIDTH-1:0]   wb_dat_i;
    logic [WIDTH-1:0]   data_o;
    logic               valid_o, ready_i;

    always #5 clk = ~clk;

    wb_burst_reader #(.ADDR(ADDR), .WIDTH(WIDTH), .BURST(BURST), .FLOG2(FLOG2)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i), .base_i(base_i), .count_i(count_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_cti_o(wb_cti_o),
        .wb_bte_o(wb_bte_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    int unsigned      vectors = 0;
    int unsigned      miscompares = 0;
    logic [WIDTH-1:0] bram [1 << ADDR];
    logic [WIDTH-1:0] exp_data [$];
    logic [ADDR-1:0]  exp_adr [$];
    logic [2:0]       exp_cti [$];
    bit               rdy_hold = 1'b0;
    bit               gap_pending = 1'b0;
    int               err_at = -1;
    int               beat_idx = 0;
    int unsigned      ack_cnt = 0;
    int unsigned      done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: split the block into bursts of min(BURST, remaining); keep the first 'limit' beats.
    task automatic expect_xfer(input int unsigned base, input int unsigned cnt, input int unsigned limit);
        int unsigned r = cnt;
        int unsigned a = base;
        int unsigned beats = 0;
        while (r > 0) begin
            int unsigned n = (r < BURST) ? r : BURST;
            for (int k = 0; k < int'(n); k++) begin
                if (beats < limit) begin
                    exp_adr.push_back(ADDR'(a));
                    exp_cti.push_back((k == int'(n) - 1) ? 3'b111 : 3'b010);
                    exp_data.push_back(bram[ADDR'(a)]);
                end
                beats++;
                a++;
            end
            r -= n;
        end
    endtask

    // Consumer: random ready, or held low for backpressure tests.
    initial begin
        ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            ready_i = rdy_hold ? 1'b0 : ($urandom_range(3) != 0);
        end
    end

    // Stream monitor: each pop is compared with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && done_o) done_cnt++;
            if (!rst && valid_o && ready_i) begin
                if (exp_data.size() == 0) fail("stream_extra_word");
                else check("stream_data", 64'(data_o), 64'(exp_data.pop_front()));
            end
        end
    end

    // Wishbone slave with random wait states; checks each acknowledged beat.
    initial begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (gap_pending) begin
                check("cyc_gap_after_last", 64'(wb_cyc_o), 64'(0));
                gap_pending = 1'b0;
            end
            if (!busy_o) beat_idx = 0;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (wb_cyc_o && wb_stb_o && !rst) begin
                if (beat_idx == err_at) begin
                    wb_err_i = 1'b1;
                end else if ($urandom_range(3) != 0) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = bram[wb_adr_o];
                    beat_idx++;
                    ack_cnt++;
                    if (exp_adr.size() == 0) fail("bus_extra_beat");
                    else begin
                        check("bus_adr", 64'(wb_adr_o), 64'(exp_adr.pop_front()));
                        check("bus_cti", 64'(wb_cti_o), 64'(exp_cti.pop_front()));
                    end
                    check("bus_we_bte_sel", 64'({wb_we_o, wb_bte_o, wb_sel_o}), 64'({1'b0, 2'b00, 4'hf}));
                    gap_pending = (wb_cti_o == 3'b111);
                end else begin
`ifndef WB_BURST_READER_ERR_EN
                    wb_err_i = ($urandom_range(1) == 1);
`endif
                end
            end
        end
    end

    task automatic run_xfer(input int unsigned base, input int unsigned cnt, input bit poke,
                            input int unsigned hold, input int err_beat);
        int unsigned t;
        int unsigned a0;
        int unsigned d0;
        err_at = err_beat;
        expect_xfer(base, cnt, (err_beat >= 0) ? int'(err_beat) : cnt);
        if (hold > 0) begin
            rdy_hold = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        a0 = ack_cnt;
        d0 = done_cnt;
        start_i = 1'b1;
        base_i  = ADDR'(base);
        count_i = cnt[ADDR:0];
        @(negedge clk);
        start_i = 1'b0;
        if (cnt == 0) check("done_after_start", 64'(done_o), 64'(1));
        else          check("busy_after_start", 64'(busy_o), 64'(1));
        check("err_cleared_on_start", 64'(err_o), 64'(0));
        if (poke && busy_o && !done_o) begin
            start_i = 1'b1;
            base_i  = ADDR'($urandom);
            count_i = (ADDR + 1)'(7);
            @(negedge clk);
            start_i = 1'b0;
        end
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("fetched_while_blocked", 64'(ack_cnt - a0), 64'(DEPTH));
            check("cyc_low_while_full", 64'(wb_cyc_o), 64'(0));
            rdy_hold = 1'b0;
        end
        t = 0;
        while (!done_o && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!done_o) fail("done_timeout");
        if (poke) begin
            start_i = 1'b1;
            count_i = (ADDR + 1)'(5);
        end
        @(negedge clk);
        start_i = 1'b0;
        check("done_one_cycle", 64'(done_o), 64'(0));
        check("busy_after_done", 64'(busy_o), 64'(0));
        check("err_after_done", 64'(err_o), 64'(err_beat >= 0));
        if (cnt == 0) check("cyc_never_on_zero", 64'(wb_cyc_o), 64'(0));
        t = 0;
        while (exp_data.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("stream_words_missing", 64'(exp_data.size()), 64'(0));
        check("bus_beats_missing", 64'(exp_adr.size()), 64'(0));
        #1;
        check("done_pulses", 64'(done_cnt - d0), 64'(1));
        err_at = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        rst     = 1'b1;
        start_i = 1'b0;
        base_i  = '0;
        count_i = '0;
        for (int i = 0; i < (1 << ADDR); i++) bram[i] = WIDTH'(i);
        repeat (3) @(negedge clk);
        check("rst_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'(0));
        check("rst_busy_done_err", 64'({busy_o, done_o, err_o}), 64'(0));
        check("rst_valid", 64'(valid_o), 64'(0));
        check("rst_cti_adr", 64'({wb_cti_o, wb_adr_o}), 64'(0));
        rst = 1'b0;

        run_xfer(0, 8, 1'b0, 0, -1);
        run_xfer(0, 6, 1'b1, 0, -1);
        run_xfer(510, 4, 1'b0, 0, -1);
        run_xfer(37, 32, 1'b0, 200, -1);
        run_xfer(100, 0, 1'b1, 0, -1);
`ifdef WB_BURST_READER_ERR_EN
        run_xfer(0, 8, 1'b0, 0, 1);
        run_xfer(20, 3, 1'b0, 0, -1);
`endif

        for (int i = 0; i < (1 << ADDR); i++) bram[i] = $urandom;
        for (int n = 0; n < 12; n++)
            run_xfer($urandom_range((1 << ADDR) - 1), $urandom_range(40, 1), 1'(($urandom_range(1))), 0, -1);

        // Reset in the middle of a transfer: bus released, FIFO flushed, no done pulse.
        expect_xfer(5, 20, 20);
        @(negedge clk);
        start_i = 1'b1;
        base_i  = ADDR'(5);
        count_i = (ADDR + 1)'(20);
        @(negedge clk);
        start_i = 1'b0;
        t = 0;
        while (!wb_cyc_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!wb_cyc_o) fail("cyc_timeout_before_reset");
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cyc", 64'({wb_cyc_o, wb_stb_o}), 64'(0));
        check("midrst_done_busy", 64'({done_o, busy_o}), 64'(0));
        check("midrst_valid", 64'(valid_o), 64'(0));
        rst = 1'b0;
        exp_data.delete();
        exp_adr.delete();
        exp_cti.delete();
        @(negedge clk);
        check("midrst_no_done", 64'(done_o), 64'(0));
        run_xfer(300, 9, 1'b0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
